// File: rtl/fp_iter_unit.sv
// Multi-cycle truncating FP add/sub/mul/min/max unit with
// valid/ready handshakes on the operand and result sides.
module fp_iter_unit #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int FLEN  = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] result,
    output logic [4:0]      fflags
);
    localparam int M  = MAN_W + 1;
    localparam int W  = M + 4;
    localparam int EW = EXP_W + 2;
    localparam int PW = $clog2(W);
    localparam int CW = $clog2(MAN_W + 2);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_MIN = 3'b011;
    localparam logic [2:0] OP_MAX = 3'b100;

    localparam logic [FLEN-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [FLEN-2:0] INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [FLEN-2:0] MAXF =
        {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    localparam logic [FLEN-2:0] ZERO = '0;

    localparam logic signed [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);
    localparam logic [EW-1:0] SH_MAX      = EW'(MAN_W + 3);
    localparam logic [CW-1:0] CNT_LAST    = CW'(MAN_W + 1);

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, MUL, NORM, PACK, DONE
    } state_t;

    state_t               state;
    logic [2:0]           op_q;
    logic [FLEN-1:0]      a_q, b_q;
    logic                 sx, sy, sub_q;
    logic                 special, zero_q, sp_nv_q;
    logic [FLEN-1:0]      sp_val_q;
    logic signed [EW-1:0] ex, ey;
    logic [W-1:0]         mx, my;
    logic [2*M-1:0]       prod;
    logic [CW-1:0]        cnt;

    logic                 sa, sb, sb_eff;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 za, zb, ia, ib, na, nb, sna, snb;
    logic [FLEN-1:0]      fla, flb;
    logic [FLEN-2:0]      mag_a, mag_b;
    logic                 a_lt_b;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign sb_eff = sb ^ (op_q == OP_SUB);

    assign za  = (ea == '0);
    assign zb  = (eb == '0);
    assign ia  = (&ea) && (fa == '0);
    assign ib  = (&eb) && (fb == '0);
    assign na  = (&ea) && (fa != '0);
    assign nb  = (&eb) && (fb != '0);
    assign sna = na && !fa[MAN_W-1];
    assign snb = nb && !fb[MAN_W-1];

    // Subnormals behave as signed zero everywhere, including MIN/MAX.
    assign fla   = za ? {sa, ZERO} : a_q;
    assign flb   = zb ? {sb, ZERO} : b_q;
    assign mag_a = fla[FLEN-2:0];
    assign mag_b = flb[FLEN-2:0];
    assign a_lt_b = (sa != sb) ? sa :
                    (sa ? (mag_a > mag_b) : (mag_a < mag_b));

    logic            sp_hit, sp_nv;
    logic [FLEN-1:0] sp_val;

    always_comb begin
        sp_hit = 1'b1;
        sp_val = QNAN;
        sp_nv  = 1'b0;
        unique case (op_q)
            OP_ADD, OP_SUB: begin
                if (na || nb)
                    sp_nv = sna || snb;
                else if (ia && ib) begin
                    if (sa != sb_eff) sp_nv = 1'b1;
                    else sp_val = {sa, INF};
                end
                else if (ia)       sp_val = {sa, INF};
                else if (ib)       sp_val = {sb_eff, INF};
                else if (za && zb) sp_val = {sa & sb_eff, ZERO};
                else if (za)       sp_val = {sb_eff, eb, fb};
                else if (zb)       sp_val = a_q;
                else               sp_hit = 1'b0;
            end
            OP_MUL: begin
                if (na || nb)
                    sp_nv = sna || snb;
                else if ((ia && zb) || (za && ib))
                    sp_nv = 1'b1;
                else if (ia || ib) sp_val = {sa ^ sb, INF};
                else if (za || zb) sp_val = {sa ^ sb, ZERO};
                else               sp_hit = 1'b0;
            end
            OP_MIN, OP_MAX: begin
                if (na && nb)
                    sp_nv = sna || snb;
                else if (na) begin
                    sp_val = flb;
                    sp_nv  = sna;
                end
                else if (nb) begin
                    sp_val = fla;
                    sp_nv  = snb;
                end
                else
                    sp_val = (a_lt_b ^ (op_q == OP_MAX)) ? fla : flb;
            end
            default: sp_nv = 1'b1;
        endcase
    end

    logic          swap;
    logic [EW-1:0] dexp;
    logic [W-1:0]  big, sml, shd;
    logic [2*W-1:0] wide;

    always_comb begin
        swap = {ey, my} > {ex, mx};
        big  = swap ? my : mx;
        sml  = swap ? mx : my;
        dexp = swap ? ey - ex : ex - ey;
        wide = {sml, {W{1'b0}}} >> dexp;
        shd  = wide[2*W-1:W];
        shd[0] = shd[0] | (|wide[W-1:0]);
        if (dexp >= SH_MAX)
            shd = {{(W-1){1'b0}}, 1'b1};
    end

    logic [PW-1:0]        msb, lsh;
    logic [W-1:0]         nm;
    logic signed [EW-1:0] ne;

    always_comb begin
        msb = '0;
        for (int i = 0; i < W; i++)
            if (mx[i]) msb = PW'(i);
        lsh = PW'(W - 2) - msb;
        if (mx[W-1]) begin
            nm = {1'b0, mx[W-1:2], mx[1] | mx[0]};
            ne = ex + EW'(1);
        end else begin
            nm = mx << lsh;
            ne = ex - EW'(lsh);
        end
    end

    logic [M:0] acc;
    assign acc = {1'b0, prod[2*M-1:M]} +
                 (prod[0] ? {1'b0, mx[W-2:3]} : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            fflags    <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            sub_q     <= 1'b0;
            special   <= 1'b0;
            zero_q    <= 1'b0;
            sp_nv_q   <= 1'b0;
            sp_val_q  <= '0;
            ex        <= '0;
            ey        <= '0;
            mx        <= '0;
            my        <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= op;
                        a_q      <= a;
                        b_q      <= b;
                        in_ready <= 1'b0;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    special  <= sp_hit;
                    sp_val_q <= sp_val;
                    sp_nv_q  <= sp_nv;
                    mx       <= {2'b01, fa, 3'b000};
                    my       <= {2'b01, fb, 3'b000};
                    if (sp_hit) begin
                        state <= PACK;
                    end else if (op_q == OP_MUL) begin
                        sx    <= sa ^ sb;
                        ex    <= $signed({2'b00, ea}) +
                                 $signed({2'b00, eb}) - BIAS;
                        prod  <= {{M{1'b0}}, 1'b1, fb};
                        cnt   <= '0;
                        state <= MUL;
                    end else begin
                        sx    <= sa;
                        sy    <= sb_eff;
                        ex    <= $signed({2'b00, ea});
                        ey    <= $signed({2'b00, eb});
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    mx    <= big;
                    my    <= shd;
                    ex    <= swap ? ey : ex;
                    sx    <= swap ? sy : sx;
                    sub_q <= sx ^ sy;
                    state <= ADD;
                end
                ADD: begin
                    mx    <= sub_q ? mx - my : mx + my;
                    state <= NORM;
                end
                MUL: begin
                    // Final cycle maps the product onto the adder's format.
                    if (cnt == CNT_LAST) begin
                        mx    <= {prod[2*M-1 -: W-1], |prod[M-4:0]};
                        state <= NORM;
                    end else begin
                        prod <= {acc, prod[M-1:1]};
                        cnt  <= cnt + CW'(1);
                    end
                end
                NORM: begin
                    mx     <= nm;
                    ex     <= ne;
                    zero_q <= (mx == '0);
                    state  <= PACK;
                end
                PACK: begin
                    if (special) begin
                        result <= sp_val_q;
                        fflags <= {sp_nv_q, 4'b0000};
                    end else if (zero_q) begin
                        result <= '0;
                        fflags <= 5'b00000;
                    end else if (ex >= EMAX) begin
                        result <= {sx, MAXF};
                        fflags <= 5'b00101;
                    end else if (ex[EW-1] || ex == '0) begin
                        result <= {sx, ZERO};
                        fflags <= 5'b00011;
                    end else begin
                        result <= {sx, ex[EXP_W-1:0], mx[W-3:3]};
                        fflags <= {4'b0000, |mx[2:0]};
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_iter_unit.sv
// Scoreboard bench for fp_iter_unit: default single precision plus
// a small EXP_W=5/MAN_W=10 instance.
module tb_fp_iter_unit;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_MIN = 3'b011;
    localparam logic [2:0] OP_MAX = 3'b100;
    localparam logic [2:0] OP_RSV = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic [4:0]  fflags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [2:0]  h_op;
    logic [15:0] h_a, h_b, h_result;
    logic [4:0]  h_fflags;

    fp_iter_unit dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .fflags(fflags)
    );

    fp_iter_unit #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op(h_op), .a(h_a), .b(h_b),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .fflags(h_fflags)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   seen   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    always @(negedge clk) begin
        if (reset || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sbq.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check($sformatf("res%0d", mon_e.id), result, mon_e.res);
                check($sformatf("flags%0d", mon_e.id),
                      32'(fflags), 32'(mon_e.flg));
                check($sformatf("lat%0d", mon_e.id),
                      32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic send(input int id, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [4:0] ef,
                        input int lat, input bit push);
        int   n = 0;
        exp_t e;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check($sformatf("accept%0d", id), 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.id  = id;
            e.res = er;
            e.flg = ef;
            e.lat = lat;
            e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        op          = OP_ADD;
        a           = '0;
        b           = '0;
        h_in_valid  = 1'b0;
        h_out_ready = 1'b1;
        h_op        = OP_ADD;
        h_a         = '0;
        h_b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_fflags", 32'(fflags), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        send(1,  OP_ADD, 32'h3FC00000, 32'h40100000,
             32'h40700000, 5'b00000, 5, 1'b1);
        send(2,  OP_MUL, 32'h40400000, 32'h3F000000,
             32'h3FC00000, 5'b00000, 28, 1'b1);
        send(3,  OP_MUL, 32'h7F7FFFFF, 32'h40000000,
             32'h7F7FFFFF, 5'b00101, 28, 1'b1);
        send(4,  OP_SUB, 32'h41200000, 32'h41200000,
             32'h00000000, 5'b00000, 5, 1'b1);
        send(5,  OP_ADD, 32'h7F800000, 32'hFF800000,
             32'h7FC00000, 5'b10000, 2, 1'b1);
        send(6,  OP_MIN, 32'h80000000, 32'h00000000,
             32'h80000000, 5'b00000, 2, 1'b1);
        send(7,  OP_MAX, 32'h7F800001, 32'h3F800000,
             32'h3F800000, 5'b10000, 2, 1'b1);
        send(8,  OP_ADD, 32'h7FC00001, 32'h3F800000,
             32'h7FC00000, 5'b00000, 2, 1'b1);
        send(9,  OP_MUL, 32'h00000000, 32'hFF800000,
             32'h7FC00000, 5'b10000, 2, 1'b1);
        send(10, OP_RSV, 32'h3F800000, 32'h3F800000,
             32'h7FC00000, 5'b10000, 2, 1'b1);
        send(11, OP_SUB, 32'h00800001, 32'h00800000,
             32'h00000000, 5'b00011, 5, 1'b1);
        send(12, OP_ADD, 32'h3F800000, 32'h30800000,
             32'h3F800000, 5'b00001, 5, 1'b1);
        send(13, OP_MUL, 32'h3F800001, 32'h3F800001,
             32'h3F800002, 5'b00001, 28, 1'b1);
        send(14, OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF,
             32'h7F7FFFFF, 5'b00101, 5, 1'b1);
        send(15, OP_ADD, 32'h3F800000, 32'hBF400000,
             32'h3E800000, 5'b00000, 5, 1'b1);
        send(16, OP_MUL, 32'hC0000000, 32'h40400000,
             32'hC0C00000, 5'b00000, 28, 1'b1);
        drain();

        out_ready = 1'b0;
        send(20, OP_ADD, 32'h3FC00000, 32'h40100000,
             32'h40700000, 5'b00000, 5, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        op = OP_MUL;
        a = 32'h40400000;
        b = 32'h3F000000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_result", result, 32'h40700000);
            check("bp_fflags", 32'(fflags), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_valid", 32'(out_valid), 32'd0);
        check("bp_rel_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_queue", 32'(sbq.size()), 32'd0);

        send(30, OP_MUL, 32'h40400000, 32'h3F000000,
             32'h3FC00000, 5'b00000, 28, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        send(31, OP_ADD, 32'h3FC00000, 32'h40100000,
             32'h40700000, 5'b00000, 5, 1'b1);
        drain();

        check("h_in_ready", 32'(h_in_ready), 32'd1);
        h_op = OP_ADD;
        h_a = 16'h3E00;
        h_b = 16'h4080;
        h_in_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        h_in_valid = 1'b0;
        n = 0;
        while (!h_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("h_valid", 32'(h_out_valid), 32'd1);
        check("h_result", 32'(h_result), 32'h4380);
        check("h_fflags", 32'(h_fflags), 32'd0);
        check("h_lat", 32'(cyc - acc), 32'd5);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
